// File: rtl/voter_session.sv
// Clocked voting session: tallies one vote per cycle from N_VOTERS identified voters,
// closes on request, full ballot or timeout, and issues a registered verdict.
module voter_session #(
   parameter int N_VOTERS = 4,
   parameter int TIMEOUT  = 16,
   parameter int TIE_PASS = 0,
   localparam int ID_W    = (N_VOTERS > 2) ? $clog2(N_VOTERS) : 1,
   localparam int CNT_W   = $clog2(N_VOTERS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vote_valid,
   input  logic [ID_W-1:0]  vote_id,
   input  logic             vote_yes,
   input  logic             close,
   output logic             busy,
   output logic             dup_err,
   output logic [CNT_W-1:0] yes_cnt,
   output logic [CNT_W-1:0] no_cnt,
   output logic             pass,
   output logic             tie,
   output logic             timed_out,
   output logic             done
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

   state_t              state_q, state_d;
   logic [N_VOTERS-1:0] mask_q, mask_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [CNT_W-1:0]    yes_q, yes_d, no_q, no_d;
   logic                pass_q, pass_d, tie_q, tie_d, to_q, to_d, dup_q, dup_d;

   // One-hot decode of the voter id; ids beyond the electorate decode to all zeros.
   logic [N_VOTERS-1:0] id_hot;
   genvar gi;
   generate
      for (gi = 0; gi < N_VOTERS; gi++) begin : g_dec
         assign id_hot[gi] = (vote_id == ID_W'(gi));
      end
   endgenerate

   logic             accept, all_set, timer_hit, close_now;
   logic [CNT_W:0]   yes_x2, n_ext;

   assign accept    = vote_valid && ((id_hot & ~mask_q) != '0);
   assign all_set   = ((mask_q | (accept ? id_hot : '0)) == '1);
   assign timer_hit = (timer_q == TW'(TIMEOUT - 1));
   assign close_now = close || all_set || timer_hit;
   assign yes_x2    = {yes_d, 1'b0};
   assign n_ext     = (CNT_W + 1)'(N_VOTERS);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      timer_d = timer_q;
      yes_d   = yes_q;
      no_d    = no_q;
      pass_d  = pass_q;
      tie_d   = tie_q;
      to_d    = to_q;
      dup_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mask_d  = '0;
               timer_d = '0;
               yes_d   = '0;
               no_d    = '0;
               pass_d  = 1'b0;
               tie_d   = 1'b0;
               to_d    = 1'b0;
               state_d = OPEN;
            end
         end
         OPEN: begin
            if (vote_valid) begin
               if (accept) begin
                  mask_d = mask_q | id_hot;
                  if (vote_yes) yes_d = yes_q + CNT_W'(1);
                  else          no_d  = no_q + CNT_W'(1);
               end else begin
                  dup_d = 1'b1;
               end
            end
            if (close_now) begin
               // Verdict uses the tally including this cycle's vote.
               pass_d  = (yes_x2 > n_ext) || ((TIE_PASS != 0) && (yes_x2 == n_ext));
               tie_d   = (yes_x2 == n_ext);
               to_d    = timer_hit && !close && !all_set;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         timer_q <= '0;
         yes_q   <= '0;
         no_q    <= '0;
         pass_q  <= 1'b0;
         tie_q   <= 1'b0;
         to_q    <= 1'b0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         timer_q <= timer_d;
         yes_q   <= yes_d;
         no_q    <= no_d;
         pass_q  <= pass_d;
         tie_q   <= tie_d;
         to_q    <= to_d;
         dup_q   <= dup_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign dup_err   = dup_q;
   assign yes_cnt   = yes_q;
   assign no_cnt    = no_q;
   assign pass      = pass_q;
   assign tie       = tie_q;
   assign timed_out = to_q;

endmodule

// File: tb/tb_voter_session.sv
// Directed bench for voter_session: N=4 with TIE_PASS 0 and 1 sharing stimulus, plus N=5.
module tb_voter_session;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Shared stimulus for the two N=4 instances.
   logic       start = 0, vote_valid = 0, vote_yes = 0, close = 0;
   logic [1:0] vote_id = 0;
   logic       busy_a, dup_a, pass_a, tie_a, to_a, done_a;
   logic [2:0] yes_a, no_a;
   logic       busy_b, dup_b, pass_b, tie_b, to_b, done_b;
   logic [2:0] yes_b, no_b;

   // N=5 instance.
   logic       start5 = 0, valid5 = 0, yes_in5 = 0, close5 = 0;
   logic [2:0] id5 = 0;
   logic       busy_c, dup_c, pass_c, tie_c, to_c, done_c;
   logic [2:0] yes_c, no_c;

   voter_session #(.N_VOTERS(4), .TIMEOUT(16), .TIE_PASS(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_id(vote_id),
      .vote_yes(vote_yes), .close(close), .busy(busy_a), .dup_err(dup_a), .yes_cnt(yes_a),
      .no_cnt(no_a), .pass(pass_a), .tie(tie_a), .timed_out(to_a), .done(done_a));

   voter_session #(.N_VOTERS(4), .TIMEOUT(16), .TIE_PASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_id(vote_id),
      .vote_yes(vote_yes), .close(close), .busy(busy_b), .dup_err(dup_b), .yes_cnt(yes_b),
      .no_cnt(no_b), .pass(pass_b), .tie(tie_b), .timed_out(to_b), .done(done_b));

   voter_session #(.N_VOTERS(5), .TIMEOUT(16), .TIE_PASS(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start5), .vote_valid(valid5), .vote_id(id5),
      .vote_yes(yes_in5), .close(close5), .busy(busy_c), .dup_err(dup_c), .yes_cnt(yes_c),
      .no_cnt(no_c), .pass(pass_c), .tie(tie_c), .timed_out(to_c), .done(done_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic vote(input logic [1:0] id, input logic y);
      vote_valid = 1; vote_id = id; vote_yes = y;
      cyc();
      vote_valid = 0;
   endtask

   task automatic open_session();
      start = 1;
      cyc();
      start = 0;
   endtask

   int n;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_yes", yes_a, 0);
      chk("rst_dup", dup_a, 0);
      @(negedge clk); rst_n = 1;
      cyc();
      // Votes and close in IDLE are ignored
      vote_valid = 1; vote_id = 0; vote_yes = 1; close = 1;
      cyc();
      vote_valid = 0; close = 0;
      chk("idle_busy", busy_a, 0);
      chk("idle_yes", yes_a, 0);
      chk("idle_dup", dup_a, 0);

      // Auto-close after full ballot: 3 yes, 1 no
      open_session();
      chk("ac_busy", busy_a, 1);
      vote(0, 1);
      chk("ac_yes1", yes_a, 1);
      vote(1, 1);
      vote(2, 1);
      chk("ac_done_early", done_a, 0);
      vote(3, 0);
      chk("ac_done", done_a, 1);
      chk("ac_yes", yes_a, 3);
      chk("ac_no", no_a, 1);
      chk("ac_pass", pass_a, 1);
      chk("ac_tie", tie_a, 0);
      chk("ac_to", to_a, 0);
      cyc();
      chk("ac_done_pulse", done_a, 0);
      chk("ac_busy_end", busy_a, 0);
      chk("ac_hold_yes", yes_a, 3);
      chk("ac_hold_pass", pass_a, 1);

      // Duplicate rejection
      open_session();
      chk("dup_clear_yes", yes_a, 0);
      vote(1, 1);
      chk("dup_none", dup_a, 0);
      chk("dup_yes1", yes_a, 1);
      vote(1, 0);
      chk("dup_pulse", dup_a, 1);
      chk("dup_yes", yes_a, 1);
      chk("dup_no", no_a, 0);
      cyc();
      chk("dup_one_cycle", dup_a, 0);
      close = 1;
      cyc();
      close = 0;
      chk("dup_done", done_a, 1);
      chk("dup_pass", pass_a, 0);
      chk("dup_to", to_a, 0);
      cyc();

      // Out-of-range id on N=5
      start5 = 1; cyc(); start5 = 0;
      chk("oor_busy", busy_c, 1);
      valid5 = 1; id5 = 6; yes_in5 = 1;
      cyc();
      valid5 = 0;
      chk("oor_dup", dup_c, 1);
      chk("oor_yes", yes_c, 0);
      chk("oor_no", no_c, 0);
      valid5 = 1; id5 = 4; yes_in5 = 1;
      cyc();
      valid5 = 0;
      chk("n5_id4_dup", dup_c, 0);
      chk("n5_id4_yes", yes_c, 1);
      close5 = 1; cyc(); close5 = 0;
      chk("n5_done", done_c, 1);
      chk("n5_pass", pass_c, 0);
      cyc();

      // Tie: 2 yes, 2 no on both TIE_PASS settings
      open_session();
      vote(0, 1);
      vote(1, 0);
      vote(2, 1);
      vote(3, 0);
      chk("tie_done", done_a, 1);
      chk("tie_tie_a", tie_a, 1);
      chk("tie_pass_a", pass_a, 0);
      chk("tie_tie_b", tie_b, 1);
      chk("tie_pass_b", pass_b, 1);
      cyc();

      // Timeout: one yes vote, no close
      open_session();
      chk("to_busy", busy_a, 1);
      n = 0;
      vote(0, 1);
      n++;
      while (!done_a && n < 40) begin
         cyc();
         n++;
      end
      chk("to_latency", n, 16);
      chk("to_done", done_a, 1);
      chk("to_flag", to_a, 1);
      chk("to_yes", yes_a, 1);
      chk("to_pass", pass_a, 0);
      cyc();
      chk("to_idle", busy_a, 0);

      // Start ignored during OPEN; vote in the closing cycle still counts
      open_session();
      chk("cl_clear_to", to_a, 0);
      vote(0, 1);
      start = 1;
      vote(1, 0);
      start = 0;
      chk("cl_start_ign_yes", yes_a, 1);
      chk("cl_start_ign_no", no_a, 1);
      vote_valid = 1; vote_id = 2; vote_yes = 1; close = 1;
      cyc();
      vote_valid = 0; close = 0;
      chk("cl_done", done_a, 1);
      chk("cl_yes", yes_a, 2);
      chk("cl_to", to_a, 0);
      chk("cl_tie", tie_a, 1);
      chk("cl_pass", pass_a, 0);
      cyc();

      // Reset mid-OPEN after 2 votes
      open_session();
      vote(0, 1);
      vote(1, 0);
      chk("mr_yes_pre", yes_a, 1);
      #2 rst_n = 0;
      #1;
      chk("mr_busy", busy_a, 0);
      chk("mr_yes", yes_a, 0);
      chk("mr_no", no_a, 0);
      chk("mr_tie", tie_a, 0);
      n = 0;
      repeat (3) begin
         cyc();
         if (done_a) n++;
      end
      chk("mr_no_done", n, 0);
      @(negedge clk); rst_n = 1;
      cyc();
      open_session();
      chk("mr_new_busy", busy_a, 1);
      chk("mr_new_yes", yes_a, 0);
      vote_valid = 1; vote_id = 3; vote_yes = 1; close = 1;
      cyc();
      vote_valid = 0; close = 0;
      chk("mr_new_done", done_a, 1);
      chk("mr_new_yes1", yes_a, 1);
      chk("mr_new_no", no_a, 0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
